// File: rtl/ir_pkg.sv
// Instruction-register package: MIPS field positions and queue entry types.
// Shared by ir_queue (IR_QUEUE_PERF_EN adds counters) and ir_field_decode.
package ir_pkg;

  localparam int IR_W   = 32;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SA_HI  = 10;
  localparam int SA_LO  = 6;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int JA_HI  = 25;
  localparam int JA_LO  = 0;

  typedef struct packed {
    logic [5:0]  opCode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] Immediate;
    logic [25:0] j_addr;
  } ir_fields_t;

  typedef struct packed {
    logic [IR_W-1:0] ins;
    logic [IR_W-1:0] pc;
  } ir_entry_t;

endpackage

// File: rtl/ir_field_decode.sv
// Combinational MIPS field slicer for the queue head.
// All fields read as zero when the head is not valid.
module ir_field_decode
  import ir_pkg::*;
(
  input  logic [IR_W-1:0] ins,
  input  logic            valid,
  output ir_fields_t      fields
);

  always_comb begin
    fields = '0;
    if (valid) begin
      fields.opCode    = ins[OP_HI:OP_LO];
      fields.rs        = ins[RS_HI:RS_LO];
      fields.rt        = ins[RT_HI:RT_LO];
      fields.rd        = ins[RD_HI:RD_LO];
      fields.sa        = ins[SA_HI:SA_LO];
      fields.Immediate = ins[IMM_HI:IMM_LO];
      fields.j_addr    = ins[JA_HI:JA_LO];
    end
  end

endmodule

// File: rtl/ir_queue.sv
// Instruction register FIFO between instruction memory and control unit.
// Define IR_QUEUE_PERF_EN to add saturating issue/stall counters.
module ir_queue
  import ir_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
`ifdef IR_QUEUE_PERF_EN
  parameter int CNT_W  = 16,
`endif
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_ins,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        opCode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        sa,
  output logic [15:0]       Immediate,
  output logic [25:0]       j_addr,
  output logic [DATA_W-1:0] out_pc,
  output logic [PTR_W:0]    level
`ifdef IR_QUEUE_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_issued,
  output logic [CNT_W-1:0]  perf_stall
`endif
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  ir_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  ir_entry_t        head;
  ir_fields_t       f;

  // Full/empty come from level alone; pointers wrap freely.
  assign in_ready  = (level != FULL);
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST && !flush && push)
      mem[wr_ptr] <= '{ins: in_ins, pc: in_pc};
  end

  ir_field_decode u_dec (
    .ins    (head.ins),
    .valid  (out_valid),
    .fields (f)
  );

  assign opCode    = f.opCode;
  assign rs        = f.rs;
  assign rt        = f.rt;
  assign rd        = f.rd;
  assign sa        = f.sa;
  assign Immediate = f.Immediate;
  assign j_addr    = f.j_addr;
  assign out_pc    = out_valid ? head.pc : '0;

`ifdef IR_QUEUE_PERF_EN
  // A pop coinciding with flush is dropped, so it is not counted as issued.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (pop && !flush && perf_issued != '1)
        perf_issued <= perf_issued + 1'b1;
      if (out_ready && !out_valid && perf_stall != '1)
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ir_queue.sv
// Bench for ir_queue: directed cases plus random traffic vs a queue model.
// Default build (IR_QUEUE_PERF_EN undefined).
module tb_ir_queue;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ins;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  opCode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [15:0] Immediate;
  logic [25:0] j_addr;
  logic [31:0] out_pc;
  logic [2:0]  level;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_next;

  always #5 CLK = ~CLK;

  ir_queue #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ins    (in_ins),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .opCode    (opCode),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .sa        (sa),
    .Immediate (Immediate),
    .j_addr    (j_addr),
    .out_pc    (out_pc),
    .level     (level)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs from the model queue, fields by shift/mask arithmetic.
  task automatic check_model();
    logic [31:0] h;
    logic [31:0] p;
    bit          v;
    v = (q.size() != 0);
    h = v ? q[0].ins : 32'd0;
    p = v ? q[0].pc  : 32'd0;
    chk("out_valid", {31'd0, out_valid}, {31'd0, v});
    chk("in_ready",  {31'd0, in_ready},  {31'd0, q.size() != DEPTH});
    chk("level",     {29'd0, level},     q.size());
    chk("opCode",    {26'd0, opCode},    h >> 26);
    chk("rs",        {27'd0, rs},        (h >> 21) % 32);
    chk("rt",        {27'd0, rt},        (h >> 16) % 32);
    chk("rd",        {27'd0, rd},        (h >> 11) % 32);
    chk("sa",        {27'd0, sa},        (h >> 6) % 32);
    chk("Immediate", {16'd0, Immediate}, h % 65536);
    chk("j_addr",    {6'd0, j_addr},     h % (1 << 26));
    chk("out_pc",    out_pc,             p);
  endtask

  // Check current outputs, advance model by the current inputs, clock.
  task automatic cycle();
    bit do_push;
    bit do_pop;
    ent_t e;
    check_model();
    do_push = in_valid && (q.size() != DEPTH);
    do_pop  = out_ready && (q.size() != 0);
    if (!RST || flush) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.ins = in_ins;
        e.pc  = in_pc;
        q.push_back(e);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_ins    = 32'd0;
    in_pc     = 32'd0;
  endtask

  initial begin
    RST = 1'b0;
    idle_inputs();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    q.delete();

    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_level",     {29'd0, level},     32'd0);
    chk("rst_opCode",    {26'd0, opCode},    32'd0);
    chk("rst_j_addr",    {6'd0, j_addr},     32'd0);
    chk("rst_out_pc",    out_pc,             32'd0);
    cycle();

    // Single push; out_ready in the accepting cycle must be ignored.
    in_valid  = 1'b1;
    in_ins    = 32'h8C2A0004;
    in_pc     = 32'h00000010;
    out_ready = 1'b1;
    cycle();
    idle_inputs();
    chk("lw_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lw_opCode",    {26'd0, opCode},    32'h23);
    chk("lw_rs",        {27'd0, rs},        32'd1);
    chk("lw_rt",        {27'd0, rt},        32'd10);
    chk("lw_imm",       {16'd0, Immediate}, 32'h0004);
    chk("lw_out_pc",    out_pc,             32'h10);
    chk("lw_level",     {29'd0, level},     32'd1);

    // Fill to DEPTH.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_ins   = 32'h100 + i;
      in_pc    = 32'h20 + 4 * i;
      cycle();
    end
    idle_inputs();
    chk("full_level",    {29'd0, level},    32'd4);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);

    in_valid = 1'b1;
    in_ins   = 32'h555;
    in_pc    = 32'h99;
    cycle();
    chk("refused_level", {29'd0, level}, 32'd4);

    out_ready = 1'b1;
    cycle();
    chk("pop_full_level", {29'd0, level},     32'd3);
    chk("pop_full_ready", {31'd0, in_ready},  32'd1);
    chk("pop_full_head",  {16'd0, Immediate}, 32'h0100);
    idle_inputs();
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("drained_level", {29'd0, level}, 32'd0);

    // Stream 1..10 with out_ready held; head must follow input order.
    exp_next = 1;
    for (int k = 1; k <= 10; k++) begin
      in_valid  = 1'b1;
      in_ins    = k;
      in_pc     = 4 * k;
      out_ready = 1'b1;
      if (out_valid) begin
        chk("stream_order", {16'd0, Immediate}, exp_next);
        exp_next++;
      end
      cycle();
    end
    in_valid = 1'b0;
    if (out_valid) begin
      chk("stream_order", {16'd0, Immediate}, exp_next);
      exp_next++;
    end
    cycle();
    chk("stream_count", exp_next, 32'd11);
    idle_inputs();

    // Flush at level 3 with push and pop asserted.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_ins   = 32'h200 + i;
      in_pc    = 32'h40 + 4 * i;
      cycle();
    end
    chk("pre_flush_level", {29'd0, level}, 32'd3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_ins    = 32'hDEADBEEF;
    in_pc     = 32'h80;
    cycle();
    idle_inputs();
    chk("flush_level",     {29'd0, level},     32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) cycle();

    // Random traffic including occasional flush and reset.
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 39) == 0);
      RST       = !($urandom_range(0, 59) == 0);
      in_ins    = $urandom;
      in_pc     = $urandom;
      cycle();
    end
    RST = 1'b1;
    idle_inputs();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised instruction register for the multicycle CPU: a DEPTH-entry FIFO of fetched instruction words with their PCs.
- The head entry is decoded into MIPS fields (opCode, rs, rt, rd, sa, Immediate, j_addr).
- Sits between instruction memory and the control unit. Decouples fetch from decode with a valid/ready handshake and a flush for taken branches and jumps.

Parameters:
- DATA_W, 32, instruction and PC width; field decode requires 32.
- DEPTH, 4, queue entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, do not override.
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous, active-low.
- in_valid  input  1  fetch side presents an instruction.
- in_ready  output  1  queue can accept an entry.
- in_ins  input  DATA_W  instruction word.
- in_pc  input  DATA_W  PC of in_ins.
- flush  input  1  discard all entries (taken branch or jump).
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode consumes the head.
- opCode  output  6  head[31:26].
- rs  output  5  head[25:21].
- rt  output  5  head[20:16].
- rd  output  5  head[15:11].
- sa  output  5  head[10:6].
- Immediate  output  16  head[15:0].
- j_addr  output  26  head[25:0].
- out_pc  output  DATA_W  PC of the head entry.
- level  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (RST=0 at a rising edge): wr_ptr=0, rd_ptr=0, level=0. This gives out_valid=0 and in_ready=1. Storage is not reset. Reset takes priority over flush, push and pop, and aborts any operation in progress.
- Push: in_valid && in_ready at an edge writes {in_ins, in_pc} at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: out_valid && out_ready at an edge; rd_ptr increments modulo DEPTH.
- in_ready = (level != DEPTH). It is independent of out_ready, so there is no combinational in-to-out path. When full, a push is refused even if a pop occurs in the same cycle.
- out_valid = (level != 0).
- Simultaneous push and pop with level between 1 and DEPTH-1: level is unchanged and both pointers advance.
- Push into an empty queue: level becomes 1. The instruction appears on the outputs in the cycle after the accepting edge, so latency is 1. An out_ready asserted in the accepting cycle is ignored.
- Pointer wrap: natural modulo DEPTH; full versus empty is distinguished by level only.
- Decoded fields and out_pc are combinational slices of the head entry. They are forced to 0 while out_valid=0, so the bench sees deterministic zeros.
- Head outputs are stable while out_valid && !out_ready.
- Flush (RST=1): at the edge, wr_ptr=rd_ptr=0 and level=0. Any push or pop in the same cycle is dropped. in_ready remains 1 during the flush cycle, but the word is discarded.
- No overflow or underflow is possible; handshake qualification blocks both.

Optional Feature:
- Macro: IR_QUEUE_PERF_EN.
- Defined: adds two outputs, perf_issued and perf_stall (CNT_W each), both reset to 0.
  - perf_issued increments on every pop.
  - perf_stall increments each cycle with out_ready=1 && out_valid=0.
  - Both saturate at all-ones.
  - Both cleared by reset only, not by flush.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package ir_pkg holds:
  - Field bit-position constants: OP_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO, SA_HI/LO, IMM_HI/LO, JA_HI/LO.
  - The ir_fields_t struct {opCode, rs, rt, rd, sa, Immediate, j_addr}.
  - The ir_entry_t struct {ins, pc}.
- One sub-module, ir_field_decode: purely combinational; takes instruction plus valid and returns ir_fields_t, zeroed when not valid.
- FIFO storage and pointers stay in ir_queue.

Test Plan:
- Reset then idle: RST=0 for 2 cycles, then RST=1 → out_valid=0, in_ready=1, level=0, all fields 0.
- Single push: in_ins=0x8C2A0004 at pc 0x00000010 → next cycle out_valid=1, opCode=0x23, rs=1, rt=10, Immediate=0x0004, out_pc=0x10.
- Fill, then pop with simultaneous push: DEPTH=4, push 4 words with out_ready=0 → in_ready=0, level=4. A 5th push is refused. Pop once with in_valid=1 → level=3, and the 5th word is not taken that cycle.
- Order and wrap: stream 10 words 0x00000001..0x0000000A with out_ready=1 → output order matches input, and pointers wrap twice.
- Flush mid-stream: level=3, flush=1 with push and pop asserted → next cycle level=0, out_valid=0. The pushed word never appears.
- Reset mid-operation with IR_QUEUE_PERF_EN defined: level=2, perf_issued=5, RST=0 → level=0, perf_issued=0, perf_stall=0.
